// File: rtl/motor_timer_ctrl.sv
// motor_timer_ctrl: off-timer setting selection, 1 s prescaler and countdown with expiry pulse
module motor_timer_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_timer,
  input  logic       i_motor_on,
  output logic [4:0] o_timeState,
  output logic [4:0] o_time,
  output logic       o_running,
  output logic       o_expire
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] EXPIRE = 2'd2;
  logic [1:0]    state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [4:0]    set_n, rem_n, adv;
  logic          tick;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign adv  = o_timeState == 5'd0  ? 5'd5  :
                o_timeState == 5'd5  ? 5'd10 :
                o_timeState == 5'd10 ? 5'd15 :
                o_timeState == 5'd15 ? 5'd30 : 5'd0;
  // next-state: abort beats press, press beats tick; the displayed setting/time are the state itself
  always_comb begin
    state_n = state;
    presc_n = presc;
    set_n   = o_timeState;
    rem_n   = o_time;
    case (state)
      IDLE: begin
        presc_n = '0;
        if (i_btn_timer && i_motor_on) begin
          set_n   = 5'd5;
          rem_n   = 5'd5;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!i_motor_on) begin
          set_n   = 5'd0;
          rem_n   = 5'd0;
          presc_n = '0;
          state_n = IDLE;
        end else if (i_btn_timer) begin
          set_n   = adv;
          rem_n   = adv;
          presc_n = '0;
          state_n = adv == 5'd0 ? IDLE : RUN;
        end else begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            rem_n   = o_time > 5'd1 ? o_time - 5'd1 : 5'd0;
            state_n = o_time > 5'd1 ? RUN : EXPIRE;
          end
        end
      end
      default: begin
        set_n   = 5'd0;
        rem_n   = 5'd0;
        presc_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  // state and registered outputs; status flags are decoded from the next state so they align with it
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      presc       <= '0;
      o_timeState <= 5'd0;
      o_time      <= 5'd0;
      o_running   <= 1'b0;
      o_expire    <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      o_timeState <= set_n;
      o_time      <= rem_n;
      o_running   <= state_n == RUN;
      o_expire    <= state_n == EXPIRE;
    end
  end
endmodule

// File: tb/tb_motor_timer_ctrl.sv
// tb_motor_timer_ctrl: directed vector table plus hand-written corner sequences at TICK_DIV = 4
module tb_motor_timer_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, btn = 1'b0, motor = 1'b0;
  logic [4:0] ts, tm;
  logic       run, ex;
  int         checks = 0, errors = 0, exp_cnt = 0;
  typedef struct {
    logic       btn;
    logic       motor;
    logic [4:0] ts;
    logic [4:0] tm;
    logic       run;
    logic       ex;
  } vec_t;
  vec_t vt[18];

  motor_timer_ctrl #(.TICK_DIV(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_btn_timer(btn), .i_motor_on(motor),
    .o_timeState(ts), .o_time(tm), .o_running(run), .o_expire(ex)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ex) exp_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask

  task automatic chk_all(input string n, input int ets, input int etm, input int erun, input int eex);
    chk({n, ".timeState"}, int'(ts), ets);
    chk({n, ".time"}, int'(tm), etm);
    chk({n, ".running"}, int'(run), erun);
    chk({n, ".expire"}, int'(ex), eex);
  endtask

  task automatic press();
    btn = 1'b1;
    step();
    btn = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 5'd10, 5'd10, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 5'd10, 5'd10, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 5'd15, 5'd15, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 5'd15, 5'd15, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 5'd30, 5'd30, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 5'd30, 5'd30, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b1, 5'd5,  5'd4,  1'b1, 1'b0};
    vt[17] = '{1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0};

    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("post_reset", 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      btn   = vt[i].btn;
      motor = vt[i].motor;
      step();
      chk_all($sformatf("vec%0d", i), int'(vt[i].ts), int'(vt[i].tm), int'(vt[i].run), int'(vt[i].ex));
    end
    btn = 1'b0;
    chk("table_no_expire", exp_cnt, 0);

    motor = 1'b1;
    press();
    chk_all("basic_load", 5, 5, 1, 0);
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("basic_c%0d.time", c), int'(tm), 5 - c / 4);
      chk($sformatf("basic_c%0d.running", c), int'(run), int'(c < 20));
      chk($sformatf("basic_c%0d.expire", c), int'(ex), int'(c == 20));
    end
    step();
    chk_all("basic_idle", 0, 0, 0, 0);
    chk("basic_expire_count", exp_cnt, 1);

    press();
    step();
    press();
    chk_all("abort_load10", 10, 10, 1, 0);
    repeat (8) step();
    chk("abort_before.time", int'(tm), 8);
    motor = 1'b0;
    step();
    chk_all("abort", 0, 0, 0, 0);
    motor = 1'b1;
    repeat (50) step();
    chk_all("abort_stays_idle", 0, 0, 0, 0);
    chk("abort_expire_count", exp_cnt, 1);

    press();
    repeat (11) step();
    chk_all("collide_pre", 5, 3, 1, 0);
    press();
    chk_all("collide_press", 10, 10, 1, 0);
    repeat (3) step();
    chk("collide_hold.time", int'(tm), 10);
    step();
    chk("collide_dec.time", int'(tm), 9);
    motor = 1'b0;
    step();
    chk_all("collide_abort", 0, 0, 0, 0);
    motor = 1'b1;

    press();
    repeat (20) step();
    chk("exp_press_cycle.expire", int'(ex), 1);
    press();
    chk_all("exp_press_ignored", 0, 0, 0, 0);
    step();
    chk_all("exp_press_idle", 0, 0, 0, 0);
    chk("exp_press_expire_count", exp_cnt, 2);

    press();
    repeat (8) step();
    chk_all("areset_pre", 5, 3, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("areset_async", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    repeat (25) step();
    chk_all("areset_after", 0, 0, 0, 0);
    chk("areset_expire_count", exp_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
